// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared encodings for the fetch/decode/execute sequencer: 4-bit state codes,
// 3-bit opcode classes and strobe-vector bit positions with their state decode.
package pipe_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_CHECK    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_LATCH    = 4'd2,
        ST_DECODE   = 4'd3,
        ST_EXEC     = 4'd4,
        ST_BR       = 4'd5,
        ST_MEM      = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_IO_REQ   = 4'd8,
        ST_IO_REL   = 4'd9,
        ST_RETIRE   = 4'd10,
        ST_HALT     = 4'd11,
        ST_INT_SAVE = 4'd12,
        ST_INT_VEC  = 4'd13,
        ST_ERROR    = 4'd14
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_IO      = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_t;

    localparam int SB_I_REQ    = 0;
    localparam int SB_D_REQ    = 1;
    localparam int SB_D_WE     = 2;
    localparam int SB_HS_OUT   = 3;
    localparam int SB_IR_LD    = 4;
    localparam int SB_PC_INC   = 5;
    localparam int SB_PC_LD    = 6;
    localparam int SB_ALU_GO   = 7;
    localparam int SB_RF_WE    = 8;
    localparam int SB_INT_SAVE = 9;
    localparam int SB_INT_ACK  = 10;
    localparam int SB_RETIRE   = 11;
    localparam int SB_HALTED   = 12;
    localparam int SB_ERR      = 13;
    localparam int SB_NUM      = 14;

    // Moore decode: every output is a pure function of the state (plus latched class).
    function automatic logic [SB_NUM-1:0] decode_strobes(state_t s, cls_t c);
        logic [SB_NUM-1:0] v;
        v = '0;
        case (s)
            ST_FETCH:    v[SB_I_REQ] = 1'b1;
            ST_LATCH:    begin v[SB_IR_LD] = 1'b1; v[SB_PC_INC] = 1'b1; end
            ST_EXEC:     begin v[SB_ALU_GO] = 1'b1; v[SB_RF_WE] = 1'b1; end
            ST_BR:       v[SB_PC_LD] = 1'b1;
            ST_MEM:      begin v[SB_D_REQ] = 1'b1; v[SB_D_WE] = (c == CLS_STORE); end
            ST_MEM_WB:   v[SB_RF_WE] = 1'b1;
            ST_IO_REQ:   v[SB_HS_OUT] = 1'b1;
            ST_RETIRE:   v[SB_RETIRE] = 1'b1;
            ST_HALT:     v[SB_HALTED] = 1'b1;
            ST_INT_SAVE: v[SB_INT_SAVE] = 1'b1;
            ST_INT_VEC:  begin v[SB_PC_LD] = 1'b1; v[SB_INT_ACK] = 1'b1; end
            ST_ERROR:    v[SB_ERR] = 1'b1;
            default:     v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Instruction-memory, data-memory and four-phase I/O handshakes between the
// sequencer (master) and the memory/I/O side (slave).
interface pipe_seq_ctrl_if;
    logic i_req;
    logic i_odv;
    logic d_req;
    logic d_we;
    logic d_odv;
    logic hs_out;
    logic hs_in;

    modport master (
        output i_req, d_req, d_we, hs_out,
        input  i_odv, d_odv, hs_in
    );

    modport slave (
        input  i_req, d_req, d_we, hs_out,
        output i_odv, d_odv, hs_in
    );
endinterface

// File: rtl/pipe_seq_ctrl_wait_timer.sv
// Handshake watchdog: counts consecutive unmet wait cycles and flags the cycle
// on which the WAIT_MAX-th unmet cycle occurs.
module pipe_seq_ctrl_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int TW = $clog2(WAIT_MAX + 1);

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Never runs past WAIT_MAX-1: a hit forces the FSM out of the wait state.
    assign hit = en && (count_reg == TW'(WAIT_MAX - 1));
endmodule

// File: rtl/pipe_seq_ctrl.sv
// Fetch/decode/execute sequencer with interrupt entry, HALT, retire counter and
// sticky error. Optional handshake watchdog enabled by defining CTRL_TIMEOUT_EN.
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int OPC_W    = 6,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic [OPC_W-1:0] opcode,
    input  logic             i_pending,
    pipe_seq_ctrl_if.master  bus,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             alu_go,
    output logic             rf_we,
    output logic             int_save,
    output logic             int_ack,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted,
    output logic             err,
    output logic [3:0]       state_o
);
    state_t              state_reg, state_next;
    cls_t                cls_reg, cls_next;
    cls_t                opc_cls;
    logic [SB_NUM-1:0]   strobe_reg;
    logic [CNT_W-1:0]    retire_cnt_reg;
    logic                timeout_hit;
    logic                opc_unused;

    assign opc_cls    = cls_t'(opcode[OPC_W-1 -: 3]);
    assign opc_unused = ^opcode;

`ifdef CTRL_TIMEOUT_EN
    logic wait_en;

    always_comb begin
        wait_en = 1'b0;
        case (state_reg)
            ST_FETCH:  wait_en = !bus.i_odv;
            ST_MEM:    wait_en = !bus.d_odv;
            ST_IO_REQ: wait_en = !bus.hs_in;
            ST_IO_REL: wait_en = bus.hs_in;
            default:   wait_en = 1'b0;
        endcase
    end

    pipe_seq_ctrl_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk(g_clk),
        .rst(g_clr),
        .clr(!wait_en),
        .en (wait_en),
        .hit(timeout_hit)
    );
`else
    localparam int wait_max_unused = WAIT_MAX;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cls_next   = cls_reg;
        case (state_reg)
            ST_CHECK:    state_next = i_pending ? ST_INT_SAVE : ST_FETCH;
            ST_INT_SAVE: state_next = ST_INT_VEC;
            ST_INT_VEC:  state_next = ST_FETCH;
            ST_FETCH: begin
                if (bus.i_odv)        state_next = ST_LATCH;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_LATCH:    state_next = ST_DECODE;
            ST_DECODE: begin
                cls_next = opc_cls;
                case (opc_cls)
                    CLS_NOP:    state_next = ST_RETIRE;
                    CLS_ALU:    state_next = ST_EXEC;
                    CLS_LOAD:   state_next = ST_MEM;
                    CLS_STORE:  state_next = ST_MEM;
                    CLS_BRANCH: state_next = ST_BR;
                    CLS_IO:     state_next = ST_IO_REQ;
                    CLS_HALT:   state_next = ST_HALT;
                    default:    state_next = ST_ERROR;
                endcase
            end
            ST_EXEC:     state_next = ST_RETIRE;
            ST_BR:       state_next = ST_RETIRE;
            ST_MEM: begin
                // A met handshake beats a watchdog hit on the same cycle.
                if (bus.d_odv)        state_next = (cls_reg == CLS_LOAD) ? ST_MEM_WB : ST_RETIRE;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_MEM_WB:   state_next = ST_RETIRE;
            ST_IO_REQ: begin
                if (bus.hs_in)        state_next = ST_IO_REL;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_IO_REL: begin
                if (!bus.hs_in)       state_next = ST_RETIRE;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_RETIRE:   state_next = ST_CHECK;
            ST_HALT:     if (i_pending) state_next = ST_INT_SAVE;
            ST_ERROR:    state_next = ST_ERROR;
            default:     state_next = ST_ERROR;
        endcase
    end

    // Strobes are registered from the next state so they align with state_reg.
    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            state_reg      <= ST_CHECK;
            cls_reg        <= CLS_NOP;
            strobe_reg     <= '0;
            retire_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cls_reg    <= cls_next;
            strobe_reg <= decode_strobes(state_next, cls_next);
            if (state_reg == ST_RETIRE) begin
                retire_cnt_reg <= retire_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.i_req  = strobe_reg[SB_I_REQ];
    assign bus.d_req  = strobe_reg[SB_D_REQ];
    assign bus.d_we   = strobe_reg[SB_D_WE];
    assign bus.hs_out = strobe_reg[SB_HS_OUT];
    assign ir_ld      = strobe_reg[SB_IR_LD];
    assign pc_inc     = strobe_reg[SB_PC_INC];
    assign pc_ld      = strobe_reg[SB_PC_LD];
    assign alu_go     = strobe_reg[SB_ALU_GO];
    assign rf_we      = strobe_reg[SB_RF_WE];
    assign int_save   = strobe_reg[SB_INT_SAVE];
    assign int_ack    = strobe_reg[SB_INT_ACK];
    assign retire     = strobe_reg[SB_RETIRE];
    assign halted     = strobe_reg[SB_HALTED];
    assign err        = strobe_reg[SB_ERR];
    assign retire_cnt = retire_cnt_reg;
    assign state_o    = state_reg;
endmodule
